// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback request, load-issue and register-file write signals shared by the
// execute/load requesters and the writeback arbiter.
interface regfile_writeback_arbiter_if;
   logic        exValid;
   logic [4:0]  exAddress;
   logic [31:0] exData;
   logic        exReady;
   logic        memValid;
   logic [4:0]  memAddress;
   logic [31:0] memData;
   logic        memReady;
   logic        loadIssue;
   logic [4:0]  loadIssueAddress;
   logic [4:0]  rdAddress;
   logic [31:0] rd;
   logic        rdWriteEnable;
   logic [31:0] pendingMask;

   modport master (
      output exValid, exAddress, exData, memValid, memAddress, memData,
             loadIssue, loadIssueAddress,
      input  exReady, memReady, rdAddress, rd, rdWriteEnable, pendingMask
   );

   modport slave (
      input  exValid, exAddress, exData, memValid, memAddress, memData,
             loadIssue, loadIssueAddress,
      output exReady, memReady, rdAddress, rd, rdWriteEnable, pendingMask
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Arbitrates the register-file write port between execute and load writeback
// (execute first, with a load starvation guard) and tracks pending loads.
module regfile_writeback_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                           clock,
   input logic                           reset,
   regfile_writeback_arbiter_if.slave    bus
);

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   logic        ex_grant;
   logic        mem_grant;
   logic        starved;

   logic [3:0]  starve_q, starve_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_we_q, rd_we_d;
   logic [31:0] pending_q, pending_d;

   // Load wins a contended cycle only once it has been refused Limit times.
   assign starved   = (starve_q == Limit);
   assign mem_grant = bus.memValid & (~bus.exValid | starved);
   assign ex_grant  = bus.exValid & ~mem_grant;

   assign bus.exReady  = ex_grant;
   assign bus.memReady = mem_grant;

   always_comb begin
      starve_d = starve_q;
      if (!bus.memValid || mem_grant) begin
         starve_d = 4'd0;
      end else if (!starved) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      rd_we_d   = 1'b0;
      if (ex_grant) begin
         rd_addr_d = bus.exAddress;
         rd_data_d = bus.exData;
         rd_we_d   = (bus.exAddress != 5'd0);
      end else if (mem_grant) begin
         rd_addr_d = bus.memAddress;
         rd_data_d = bus.memData;
         rd_we_d   = (bus.memAddress != 5'd0);
      end
   end

   // Set after clear so a same-cycle reissue to the same register stays pending.
   always_comb begin
      pending_d = pending_q;
      if (mem_grant) begin
         pending_d[bus.memAddress] = 1'b0;
      end
      if (bus.loadIssue) begin
         pending_d[bus.loadIssueAddress] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_q  <= 4'd0;
         rd_addr_q <= 5'd0;
         rd_data_q <= 32'd0;
         rd_we_q   <= 1'b0;
         pending_q <= 32'd0;
      end else begin
         starve_q  <= starve_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         rd_we_q   <= rd_we_d;
         pending_q <= pending_d;
      end
   end

   assign bus.rdAddress     = rd_addr_q;
   assign bus.rd            = rd_data_q;
   assign bus.rdWriteEnable = rd_we_q;
   assign bus.pendingMask   = pending_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: literal checks in the stimulus
// plus a per-cycle comparison against a behavioural model.
module tb_regfile_writeback_arbiter;

   localparam int unsigned Limit = 4;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   regfile_writeback_arbiter_if bus ();

   regfile_writeback_arbiter #(
      .STARVE_LIMIT(Limit)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic li, input logic [4:0] la);
      bus.exValid          = ev;
      bus.exAddress        = ea;
      bus.exData           = ed;
      bus.memValid         = mv;
      bus.memAddress       = ma;
      bus.memData          = md;
      bus.loadIssue        = li;
      bus.loadIssueAddress = la;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Behavioural model: count how long the load side has waited, pick the
   // winner, and track what the register file should see next cycle.
   int          m_wait;
   logic [31:0] m_pend;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_we;

   always @(negedge clock) begin
      logic exp_mem;
      logic exp_ex;
      if (!reset) begin
         m_wait = 0;
         m_pend = 32'd0;
         m_addr = 5'd0;
         m_data = 32'd0;
         m_we   = 1'b0;
      end
      check("model_rdWriteEnable", {31'd0, bus.rdWriteEnable}, {31'd0, m_we});
      check("model_rdAddress", {27'd0, bus.rdAddress}, {27'd0, m_addr});
      check("model_rd", bus.rd, m_data);
      check("model_pendingMask", bus.pendingMask, m_pend);
      exp_mem = bus.memValid && (!bus.exValid || m_wait >= int'(Limit));
      exp_ex  = bus.exValid && !exp_mem;
      check("model_exReady", {31'd0, bus.exReady}, {31'd0, exp_ex});
      check("model_memReady", {31'd0, bus.memReady}, {31'd0, exp_mem});
      if (reset) begin
         if (exp_ex) begin
            m_addr = bus.exAddress;
            m_data = bus.exData;
            m_we   = (bus.exAddress != 0);
         end else if (exp_mem) begin
            m_addr = bus.memAddress;
            m_data = bus.memData;
            m_we   = (bus.memAddress != 0);
         end else begin
            m_we = 1'b0;
         end
         if (bus.memValid && !exp_mem) m_wait = (m_wait < int'(Limit)) ? m_wait + 1 : m_wait;
         else m_wait = 0;
         if (exp_mem) m_pend[bus.memAddress] = 1'b0;
         if (bus.loadIssue && bus.loadIssueAddress != 0) m_pend[bus.loadIssueAddress] = 1'b1;
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle();
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      next_cycle();
      check("reset_rdWriteEnable", {31'd0, bus.rdWriteEnable}, 32'd0);
      check("reset_rdAddress", {27'd0, bus.rdAddress}, 32'd0);
      check("reset_rd", bus.rd, 32'd0);
      check("reset_pendingMask", bus.pendingMask, 32'd0);
      check("reset_readies", {30'd0, bus.exReady, bus.memReady}, 32'd0);

      // Basic execute write.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 check("ex_ready", {31'd0, bus.exReady}, 32'd1);
      next_cycle();
      check("ex_we", {31'd0, bus.rdWriteEnable}, 32'd1);
      check("ex_addr", {27'd0, bus.rdAddress}, 32'd5);
      check("ex_data", bus.rd, 32'hDEADBEEF);

      // Write to x0 is accepted but not performed.
      drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 check("x0_ready", {31'd0, bus.exReady}, 32'd1);
      next_cycle();
      check("x0_we", {31'd0, bus.rdWriteEnable}, 32'd0);
      idle();
      next_cycle();

      // Continuous contention: load wins every fifth cycle.
      drive(1'b1, 5'd3, 32'h0000_0300, 1'b1, 5'd9, 32'h0000_0900, 1'b0, 5'd0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("starve_memReady", {31'd0, bus.memReady}, (i % 5 == 4) ? 32'd1 : 32'd0);
         check("starve_exReady", {31'd0, bus.exReady}, (i % 5 == 4) ? 32'd0 : 32'd1);
         next_cycle();
      end
      idle();
      next_cycle();

      // Pending-load scoreboard.
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      next_cycle();
      check("pend_set", bus.pendingMask, 32'h0000_0080);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_00AA, 1'b0, 5'd0);
      next_cycle();
      check("pend_clear", bus.pendingMask, 32'd0);
      check("load_addr", {27'd0, bus.rdAddress}, 32'd7);
      check("load_data", bus.rd, 32'h0000_00AA);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_00BB, 1'b1, 5'd7);
      next_cycle();
      check("pend_set_wins", bus.pendingMask, 32'h0000_0080);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_00CC, 1'b0, 5'd0);
      next_cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      next_cycle();
      check("pend_x0_ignored", bus.pendingMask, 32'd0);
      idle();
      next_cycle();

      // Load granted as soon as execute drops; wait count restarts.
      drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0);
      #1 check("toggle_mem_refused", {31'd0, bus.memReady}, 32'd0);
      next_cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0);
      #1 check("toggle_mem_granted", {31'd0, bus.memReady}, 32'd1);
      next_cycle();
      drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd4, 32'h0000_0055, 1'b1, 5'd12);
      #1 check("toggle_ex_after_reset_count", {31'd0, bus.exReady}, 32'd1);
      next_cycle();
      idle();
      check("pre_reset_we", {31'd0, bus.rdWriteEnable}, 32'd1);
      check("pre_reset_pend", bus.pendingMask, 32'h0000_1000);

      // Asynchronous reset mid-cycle drops the registered write at once.
      #1 reset = 1'b0;
      #1;
      check("async_we", {31'd0, bus.rdWriteEnable}, 32'd0);
      check("async_pend", bus.pendingMask, 32'd0);
      check("async_addr", {27'd0, bus.rdAddress}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
